// File: rtl/reset_sequencer.sv
// Reset sequencer for the SATA PHY/core clock domain.
// Releases the transceiver PLL, PHY and core resets in strict order once the
// PLL reports a stable lock, and re-runs the whole sequence on lock loss, on a
// lock timeout or on a software restart. All outputs are registered and are
// decoded from the next state, so they change on the same edge as the FSM.
module reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned HOLD_CYCLES    = 1024,
    parameter int unsigned STEP_CYCLES    = 16
) (
    input  logic clk,
    input  logic areset_n,
    input  logic pll_locked,
    input  logic sw_restart,
    output logic pll_reset,
    output logic phy_reset,
    output logic core_reset,
    output logic ready,
    output logic lock_err
);

    // Shared down-counter width: large enough for the biggest load value.
    localparam int unsigned MAX_AB     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CD     = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int          CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_PHY_REL,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err_nxt;
    logic             lock_meta;
    logic             lock_s;

    // Counter value loaded on entry to a state: the number of edges the state
    // lasts. DONE has no duration, and a zero timeout disables WAIT_LOCK expiry.
    function automatic logic [CNT_W-1:0] load_for(input state_t s);
        logic [CNT_W-1:0] val;
        val = CNT_ZERO;
        case (s)
            ST_PLL_RST:   val = CNT_W'(PLL_RST_CYCLES);
            ST_WAIT_LOCK: val = CNT_W'(LOCK_TIMEOUT);
            ST_HOLD:      val = CNT_W'(HOLD_CYCLES);
            ST_PHY_REL:   val = CNT_W'(STEP_CYCLES);
            default:      val = CNT_ZERO;
        endcase
        return val;
    endfunction

    // Two-flop synchronizer for the asynchronous PLL lock flag.
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every flop samples its inputs from before the edge, never a sibling's new value.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // State register and shared counter.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= ST_PLL_RST;
            cnt   <= CNT_W'(PLL_RST_CYCLES);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter and lock-error decode.
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        cnt_nxt   = (cnt != CNT_ZERO) ? (cnt - CNT_ONE) : cnt;

        if (sw_restart) begin
            // Restart wins over every other transition and never flags an error.
            state_nxt = ST_PLL_RST;
        end else begin
            case (state)
                ST_PLL_RST: begin
                    if (cnt == CNT_ONE) begin
                        state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_HOLD;
                    end else if ((LOCK_TIMEOUT != 0) && (cnt == CNT_ONE)) begin
                        state_nxt = ST_PLL_RST;
                        err_nxt   = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A lock drop before the hold completes is a normal settle
                    // glitch: go back to waiting without reporting it.
                    if (!lock_s) begin
                        state_nxt = ST_WAIT_LOCK;
                    end else if (cnt == CNT_ONE) begin
                        state_nxt = ST_PHY_REL;
                    end
                end
                ST_PHY_REL: begin
                    if (!lock_s) begin
                        state_nxt = ST_PLL_RST;
                        err_nxt   = 1'b1;
                    end else if (cnt == CNT_ONE) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!lock_s) begin
                        state_nxt = ST_PLL_RST;
                        err_nxt   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_PLL_RST;
                end
            endcase
        end

        // Reload on every state entry; a restart while already in PLL_RST
        // also counts as a fresh entry.
        if (sw_restart || (state_nxt != state)) begin
            cnt_nxt = load_for(state_nxt);
        end
    end

    // Registered outputs decoded from the next state, so reassertion happens
    // on all outputs in the same edge and release follows the state order.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            pll_reset  <= 1'b1;
            phy_reset  <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
            lock_err   <= 1'b0;
        end else begin
            pll_reset  <= (state_nxt == ST_PLL_RST);
            phy_reset  <= !((state_nxt == ST_PHY_REL) || (state_nxt == ST_DONE));
            core_reset <= (state_nxt != ST_DONE);
            ready      <= (state_nxt == ST_DONE);
            lock_err   <= err_nxt;
        end
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Reset sequencer for the SATA PHY/core clock domain. It consumes the synchronous reset produced by the reset synchronizer, together with the transceiver PLL lock flag. It then drives ordered, registered reset outputs: PLL first, then PHY, then core. A lock loss, a lock timeout or a software restart re-runs the whole sequence.

## Interface

Parameters:
- PLL_RST_CYCLES, 64: edges pll_reset is held after sequence start; must be ≥1.
- LOCK_TIMEOUT, 65536: edges allowed in WAIT_LOCK before PLL is re-reset; 0 disables the timeout.
- HOLD_CYCLES, 1024: edges pll_locked must stay continuously high before phy_reset is released; must be ≥1.
- STEP_CYCLES, 16: edges between phy_reset release and core_reset release; must be ≥1.

Ports:
- clk, input, 1: sequencer clock.
- areset_n, input, 1: asynchronous, active-low reset. Drive it from the upstream synchronizer output so deassertion is clk-aligned.
- pll_locked, input, 1: PLL lock flag. Asynchronous; synchronized internally.
- sw_restart, input, 1: synchronous one-cycle request to restart the sequence.
- pll_reset, output, 1: active-high reset to the transceiver PLL.
- phy_reset, output, 1: active-high reset to PHY/OOB logic.
- core_reset, output, 1: active-high reset to link/transport logic.
- ready, output, 1: high when the sequence is complete (DONE).
- lock_err, output, 1: one-cycle pulse on a lock timeout or on a lock loss after HOLD.

## Operation

- Lock synchronizer:
  - Two flops, reset to 0.
  - lock_s is the second flop's output; all decisions use lock_s only.
- States: PLL_RST, WAIT_LOCK, HOLD, PHY_REL, DONE. The reset state is PLL_RST.
- One shared down-counter, sized $clog2 of the largest parameter plus 1.
  - It is loaded on every state entry.
  - A state "lasts N edges" means the transition happens on the Nth edge spent in the state.
- PLL_RST:
  - Lasts PLL_RST_CYCLES edges, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1 → HOLD on that edge.
  - Otherwise, if LOCK_TIMEOUT≠0 and LOCK_TIMEOUT edges have elapsed → PLL_RST, with a lock_err pulse.
- HOLD:
  - lock_s=0 → WAIT_LOCK, counter reloaded, no lock_err.
  - Otherwise lasts HOLD_CYCLES edges, then → PHY_REL.
- PHY_REL:
  - Lasts STEP_CYCLES edges, then → DONE.
  - lock_s=0 → PLL_RST with lock_err.
- DONE:
  - Stays in DONE.
  - lock_s=0 → PLL_RST with lock_err.
- sw_restart=1 in any state → PLL_RST on that edge, counter reloaded, no lock_err. It has priority over all other transitions.
- Outputs are registered, decoded from the next state:
  - pll_reset = (state==PLL_RST).
  - phy_reset = state∉{PHY_REL, DONE}.
  - core_reset = ready_n, where ready = (state==DONE).
- Invariant: core_reset=0 implies phy_reset=0, and phy_reset=0 implies pll_reset=0. Reassertion is simultaneous on all outputs; release is strictly ordered.

## Timing

- While areset_n=0, asynchronously:
  - pll_reset=1, phy_reset=1, core_reset=1.
  - ready=0, lock_err=0.
  - Sync flops=0, state=PLL_RST, counter loaded with PLL_RST_CYCLES.
- Edge numbering: edge 1 is the first rising clk after areset_n rises. Outputs reflect a transition immediately after the edge on which it occurs.
- Lock latency: a pll_locked change is visible to the FSM 2 edges later.
- Release latency with lock already high, no restart:
  - pll_reset falls after edge PLL_RST_CYCLES.
  - phy_reset falls after edge PLL_RST_CYCLES+1+HOLD_CYCLES.
  - core_reset falls and ready rises STEP_CYCLES edges later.
- Reassertion latency: lock drop to all resets high takes 3 edges (2 sync edges plus 1 FSM edge).
- lock_err: high for exactly the one cycle following the transition edge.
- Async reset mid-sequence: immediate return to reset values. No pulse on lock_err.

## Test plan

Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, HOLD_CYCLES=8, STEP_CYCLES=3.

- **Nominal:** pll_locked held 1, areset_n released.
  - pll_reset falls after edge 4; phy_reset falls after edge 13.
  - core_reset falls and ready rises after edge 16.
  - lock_err never pulses.
- **Timeout:** pll_locked held 0.
  - pll_reset falls after edge 4, rises again after edge 24 with a one-cycle lock_err.
  - Pattern repeats; phy_reset and core_reset stay 1 throughout.
- **Glitch during HOLD:** lock high, then pll_locked=0 for 1 cycle at edge 9.
  - FSM returns to WAIT_LOCK, then HOLD restarts for a full 8 edges.
  - phy_reset release is delayed accordingly; no lock_err.
- **Lock loss in DONE:** after ready=1, drop pll_locked.
  - 3 edges later: pll_reset, phy_reset, core_reset =1, ready=0, lock_err pulses once.
  - Raising lock again re-runs the ordered release.
- **sw_restart:** pulse sw_restart in PHY_REL while in WAIT_LOCK of a timeout loop.
  - Next cycle all resets =1, with the counter reloaded (pll_reset high for 4 edges).
  - No lock_err.
- **Async reset mid-DONE:** assert areset_n=0 asynchronously.
  - Outputs go to reset values without a clock edge.
  - Release reproduces the nominal timing exactly.
